// File: rtl/alu_serial_pkg.sv
// Shared encodings, FSM state type and carry-init helper for the bit-serial ALU sequencer.
// The optional abort feature in the top is enabled by defining ALU_SERIAL_ABORT_EN.
package alu_serial_pkg;

  // Arithmetic-mode operation encodings
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;

  // Logic-mode operation encodings share the same codes
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // SUB and INC start with carry 1 (two's-complement subtract, +1); everything else 0.
  function automatic logic init_carry(input logic mode, input logic [2:0] opsel);
    return (mode == MODE_ARITH) && ((opsel == OP_SUB) || (opsel == OP_INC));
  endfunction

endpackage

// File: rtl/alu_serial_shreg.sv
// WIDTH-bit parallel-load, right-shift register with serial input at the MSB end.
// Load has priority over shift.
module alu_serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_ser_in, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving a 1-bit ALU slice LSB first; builds the result and C/Z/O/S flags.
// Define ALU_SERIAL_ABORT_EN to add the abort input that cancels an operation in RUN.
//
// Handshake: start is accepted only when dbg_state==IDLE (busy low); busy stays high through
// RUN and DONE, and done pulses for exactly one cycle when result and flags become valid.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       opsel,
  input  logic             mode,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output logic             o_flag,
  output logic             s_flag,
  output logic             slice_op1,
  output logic             slice_op2,
  output logic             slice_cin,
  output logic [2:0]       slice_opsel,
  output logic             slice_mode,
  input  logic             slice_result,
  input  logic             slice_cout,
  output state_t           dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [2:0]       r_opsel;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_c;
  logic             r_z;
  logic             r_o;
  logic             r_s;

  logic             w_load;
  logic             w_shift;
  logic             w_abort;
  logic             w_last;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_res_next;

`ifdef ALU_SERIAL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_load     = (r_state == IDLE) && start;
  assign w_shift    = (r_state == RUN) && !w_abort;
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_res_next = {slice_result, w_res[WIDTH-1:1]};

  alu_serial_shreg #(.WIDTH(WIDTH)) u_shreg_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (op_a),
    .i_shift    (w_shift),
    .i_ser_in   (1'b0),
    .o_q        (w_a)
  );

  alu_serial_shreg #(.WIDTH(WIDTH)) u_shreg_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (op_b),
    .i_shift    (w_shift),
    .i_ser_in   (1'b0),
    .o_q        (w_b)
  );

  // Result fills from the MSB end; after WIDTH shifts bit 0 sits at the LSB.
  alu_serial_shreg #(.WIDTH(WIDTH)) u_shreg_res (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_shift    (w_shift),
    .i_ser_in   (slice_result),
    .o_q        (w_res)
  );

`ifdef ALU_SERIAL_ABORT_EN
  // An aborted run leaves the shift register half-written, so the visible result is a copy
  // taken only when an operation completes.
  logic [WIDTH-1:0] r_result_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_hold <= '0;
    end else if (w_shift && w_last) begin
      r_result_hold <= w_res_next;
    end
  end

  assign result = r_result_hold;
`else
  assign result = w_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_opsel <= 3'b000;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_o     <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_carry <= init_carry(mode, opsel);
            r_opsel <= opsel;
            r_mode  <= mode;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_carry <= slice_cout;
            r_cnt   <= r_cnt + CNT_ONE;
            if (w_last) begin
              // slice_cin here is the carry into the MSB, needed for signed overflow.
              r_state <= DONE;
              r_done  <= 1'b1;
              r_z     <= (w_res_next == '0);
              r_s     <= slice_result;
              r_c     <= (r_mode == MODE_ARITH) ? slice_cout : 1'b0;
              r_o     <= (r_mode == MODE_ARITH) ? (r_carry ^ slice_cout) : 1'b0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign c_flag      = r_c;
  assign z_flag      = r_z;
  assign o_flag      = r_o;
  assign s_flag      = r_s;
  assign slice_op1   = w_a[0];
  assign slice_op2   = w_b[0];
  assign slice_cin   = r_carry;
  assign slice_opsel = r_opsel;
  assign slice_mode  = r_mode;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=8) with a behavioural 1-bit slice model.
// Covers the abort feature when ALU_SERIAL_ABORT_EN is defined.
module tb_alu_serial_ctrl;
  import alu_serial_pkg::*;

  localparam int W = 8;

  // Clock and reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   opsel;
  logic         mode;
`ifdef ALU_SERIAL_ABORT_EN
  logic         abort;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_flag;
  logic         z_flag;
  logic         o_flag;
  logic         s_flag;
  logic         slice_op1;
  logic         slice_op2;
  logic         slice_cin;
  logic [2:0]   slice_opsel;
  logic         slice_mode;
  logic         slice_result;
  logic         slice_cout;
  state_t       dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .opsel        (opsel),
    .mode         (mode),
`ifdef ALU_SERIAL_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .result       (result),
    .c_flag       (c_flag),
    .z_flag       (z_flag),
    .o_flag       (o_flag),
    .s_flag       (s_flag),
    .slice_op1    (slice_op1),
    .slice_op2    (slice_op2),
    .slice_cin    (slice_cin),
    .slice_opsel  (slice_opsel),
    .slice_mode   (slice_mode),
    .slice_result (slice_result),
    .slice_cout   (slice_cout),
    .dbg_state    (dbg_state)
  );

  // Behavioural 1-bit ALU slice
  always_comb begin
    logic bb;
    bb           = 1'b0;
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    if (slice_mode == MODE_ARITH) begin
      case (slice_opsel)
        OP_ADD:  bb = slice_op2;
        OP_SUB:  bb = ~slice_op2;
        OP_INC:  bb = 1'b0;
        default: bb = 1'b1;
      endcase
      slice_result = slice_op1 ^ bb ^ slice_cin;
      slice_cout   = (slice_op1 & bb) | (slice_op1 & slice_cin) | (bb & slice_cin);
    end else begin
      case (slice_opsel)
        OP_AND:  slice_result = slice_op1 & slice_op2;
        OP_OR:   slice_result = slice_op1 | slice_op2;
        OP_XOR:  slice_result = slice_op1 ^ slice_op2;
        default: slice_result = ~slice_op1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask

  // Driver: issue one operation, wait for done (bounded), check everything, step to IDLE.
  task automatic apply_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] sel, input logic md, input logic [W-1:0] exp_res,
                          input logic ec, input logic ez, input logic eo, input logic es);
    int lat;
    op_a  = a;
    op_b  = b;
    opsel = sel;
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_result"},  32'(result), 32'(exp_res));
    check({tag, "_flags"},   {28'd0, c_flag, z_flag, o_flag, s_flag}, {28'd0, ec, ez, eo, es});
    check({tag, "_busy"},    32'(busy), 32'd1);
    tick();
    check({tag, "_idle"},    {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    int first_done;
    logic [20:0] all_out;

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    opsel = 3'b000;
    mode  = 1'b0;
`ifdef ALU_SERIAL_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    all_out = {busy, done, result, c_flag, z_flag, o_flag, s_flag,
               slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode};
    check("reset_outputs", 32'(all_out), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // Arithmetic vectors
    apply_op("add_7f_01", 8'h7F, 8'h01, OP_ADD, MODE_ARITH, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_op("sub_05_05", 8'h05, 8'h05, OP_SUB, MODE_ARITH, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_op("add_ff_01", 8'hFF, 8'h01, OP_ADD, MODE_ARITH, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_op("sub_80_01", 8'h80, 8'h01, OP_SUB, MODE_ARITH, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_op("inc_7f",    8'h7F, 8'h33, OP_INC, MODE_ARITH, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_op("dec_00",    8'h00, 8'h5A, OP_DEC, MODE_ARITH, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Logic vectors
    apply_op("xor_aa_55", 8'hAA, 8'h55, OP_XOR,  MODE_LOGIC, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_op("and_f0_0f", 8'hF0, 8'h0F, OP_AND,  MODE_LOGIC, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_op("or_0c_30",  8'h0C, 8'h30, OP_OR,   MODE_LOGIC, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_op("nota_0f",   8'h0F, 8'h00, OP_NOTA, MODE_LOGIC, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);

    // start pulses during RUN are ignored
    op_a  = 8'h12;
    op_b  = 8'h34;
    opsel = OP_ADD;
    mode  = MODE_ARITH;
    start = 1'b1;
    tick();
    start      = 1'b0;
    n_done     = 0;
    first_done = 0;
    for (int cur = 1; cur <= 13; cur++) begin
      if (cur == 3 || cur == 5) begin
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        opsel = OP_SUB;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = cur + 1;
      end
    end
    check("ignore_start_done_count", 32'(n_done), 32'd1);
    check("ignore_start_latency", 32'(first_done), 32'd9);
    check("ignore_start_result", 32'(result), 32'h46);
    check("ignore_start_flags", {28'd0, c_flag, z_flag, o_flag, s_flag}, 32'd0);
    check("ignore_start_state", 32'(dbg_state), 32'(IDLE));

    // Asynchronous reset mid-RUN
    op_a  = 8'h0F;
    op_b  = 8'h01;
    opsel = OP_ADD;
    mode  = MODE_ARITH;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    all_out = {busy, done, result, c_flag, z_flag, o_flag, s_flag,
               slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode};
    check("midrun_reset_outputs", 32'(all_out), 32'd0);
    check("midrun_reset_state", 32'(dbg_state), 32'(IDLE));
    #2;
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    check("post_reset_no_done", 32'(n_done), 32'd0);
    apply_op("post_reset_add", 8'h01, 8'h02, OP_ADD, MODE_ARITH, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SERIAL_ABORT_EN
    // abort at bit 3: no done, previous result and flags retained
    op_a  = 8'hFF;
    op_b  = 8'h01;
    opsel = OP_SUB;
    mode  = MODE_ARITH;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_falls", 32'(busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n_done++;
      tick();
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_result_kept", 32'(result), 32'h03);
    check("abort_flags_kept", {28'd0, c_flag, z_flag, o_flag, s_flag}, 32'd0);
    apply_op("after_abort_sub", 8'hFF, 8'h01, OP_SUB, MODE_ARITH, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
